// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks every input combination of a combinational DUT,
// holds each for HOLD cycles, then scores the DUT output against EXPECTED.
module truth_table_sweeper #(
    parameter int                    N_IN     = 4,
    parameter int                    HOLD     = 100,
    parameter logic [(2**N_IN)-1:0]  EXPECTED = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            dut_q,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_idx,
    output logic            mismatch
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0]     HOLD_LAST = 16'(HOLD - 1);
    localparam logic [N_IN-1:0] STIM_LAST = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] STIM_ONE  = N_IN'(1'b1);
    localparam logic [N_IN:0]   ERR_ONE   = (N_IN + 1)'(1'b1);

    state_t          state_r, state_next_s;
    logic [N_IN-1:0] stim_r, stim_next_s;
    logic [15:0]     hold_cnt_r, hold_next_s;
    logic [N_IN:0]   err_count_r, err_next_s, err_inc_s;
    logic [N_IN-1:0] first_err_idx_r, first_idx_next_s;
    logic            first_seen_r, first_seen_next_s;
    logic            pass_r, pass_next_s;
    logic            done_r, done_next_s;
    logic            mismatch_r, mismatch_next_s;
    logic            busy_r;
    logic            sample_bad_s;

    // Next-state and datapath decode; abort wins over a coincident compare.
    always_comb begin
        state_next_s      = state_r;
        stim_next_s       = stim_r;
        hold_next_s       = hold_cnt_r;
        err_next_s        = err_count_r;
        first_idx_next_s  = first_err_idx_r;
        first_seen_next_s = first_seen_r;
        pass_next_s       = pass_r;
        done_next_s       = 1'b0;
        mismatch_next_s   = 1'b0;
        sample_bad_s      = (dut_q != EXPECTED[stim_r]);
        err_inc_s         = sample_bad_s ? (err_count_r + ERR_ONE) : err_count_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s      = RUN;
                    stim_next_s       = '0;
                    hold_next_s       = 16'd0;
                    err_next_s        = '0;
                    first_idx_next_s  = '0;
                    first_seen_next_s = 1'b0;
                    pass_next_s       = 1'b0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next_s = IDLE;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    err_next_s      = err_inc_s;
                    mismatch_next_s = sample_bad_s;
                    if (sample_bad_s && !first_seen_r) begin
                        first_idx_next_s  = stim_r;
                        first_seen_next_s = 1'b1;
                    end else begin
                        first_idx_next_s  = first_err_idx_r;
                    end
                    // Last combination keeps stim so the final index stays visible.
                    if (stim_r != STIM_LAST) begin
                        stim_next_s = stim_r + STIM_ONE;
                        hold_next_s = 16'd0;
                    end else begin
                        state_next_s = DONE;
                        done_next_s  = 1'b1;
                        pass_next_s  = (err_inc_s == '0);
                    end
                end else begin
                    hold_next_s = hold_cnt_r + 16'd1;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            stim_r          <= '0;
            hold_cnt_r      <= 16'd0;
            err_count_r     <= '0;
            first_err_idx_r <= '0;
            first_seen_r    <= 1'b0;
            pass_r          <= 1'b0;
            done_r          <= 1'b0;
            mismatch_r      <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            stim_r          <= stim_next_s;
            hold_cnt_r      <= hold_next_s;
            err_count_r     <= err_next_s;
            first_err_idx_r <= first_idx_next_s;
            first_seen_r    <= first_seen_next_s;
            pass_r          <= pass_next_s;
            done_r          <= done_next_s;
            mismatch_r      <= mismatch_next_s;
            busy_r          <= (state_next_s == RUN);
        end
    end

    assign stim          = stim_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign err_count     = err_count_r;
    assign first_err_idx = first_err_idx_r;
    assign mismatch      = mismatch_r;

endmodule
